// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_ITERS  = DIV_DATA_W;
  localparam int unsigned DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV_ZERO,
    ST_ON,
    ST_END
  } div_state_e;

  // Counter value of the final shift-subtract step for a given operand width.
  function automatic logic [DIV_CNT_W-1:0] div_last_iter(input int unsigned width);
    return DIV_CNT_W'(width - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic              q_bit,
  output logic [DATA_W-1:0] rem_out
);

  logic [DATA_W:0] trial;
  logic [DATA_W:0] diff;

  // rem_in < divisor, so trial < 2*divisor: the top bit of diff is a clean borrow.
  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[DATA_W];
    rem_out = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider: one quotient bit per cycle on absolute
// values, sign fix-up on the final step, {remainder, quotient} result.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  annul_i,
  input  logic                  start_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic                  ready_o,
  output logic [2*DATA_W-1:0]   result_o
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = div_last_iter(DATA_W);

  div_state_e           state;
  div_state_e           state_nxt;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DATA_W-1:0]    dvd_quo;
  logic [DATA_W-1:0]    rem;
  logic [DATA_W-1:0]    dsr;
  logic                 neg_q;
  logic                 neg_r;

  logic                 abort;
  logic                 launch;
  logic                 last_step;
  logic                 op1_neg;
  logic                 op2_neg;
  logic [DATA_W-1:0]    op1_abs;
  logic [DATA_W-1:0]    op2_abs;
  logic                 q_bit;
  logic [DATA_W-1:0]    rem_nxt;
  logic [DATA_W-1:0]    quo_nxt;
  logic [DATA_W-1:0]    quo_fin;
  logic [DATA_W-1:0]    rem_fin;

  always_comb begin
    abort     = flush | annul_i;
    launch    = (state == ST_IDLE) && start_i && !abort;
    last_step = (state == ST_ON) && (cnt == LAST_CNT);
    op1_neg   = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg   = signed_div_i & opdata2_i[DATA_W-1];
    op1_abs   = op1_neg ? -opdata1_i : opdata1_i;
    op2_abs   = op2_neg ? -opdata2_i : opdata2_i;
  end

  // dvd_quo shifts dividend bits out at the top while quotient bits fill in
  // at the bottom, so after the last step it holds the unsigned quotient.
  div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_in  (rem),
    .bit_in  (dvd_quo[DATA_W-1]),
    .divisor (dsr),
    .q_bit   (q_bit),
    .rem_out (rem_nxt)
  );

  always_comb begin
    quo_nxt = {dvd_quo[DATA_W-2:0], q_bit};
    quo_fin = neg_q ? -quo_nxt : quo_nxt;
    rem_fin = neg_r ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            state_nxt = (opdata2_i == '0) ? ST_DIV_ZERO : ST_ON;
          end
        end
        ST_DIV_ZERO: state_nxt = ST_END;
        ST_ON: begin
          if (cnt == LAST_CNT) begin
            state_nxt = ST_END;
          end
        end
        ST_END:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
    ready_o = (state == ST_END);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dvd_quo  <= '0;
      rem      <= '0;
      dsr      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
    end else begin
      if (launch) begin
        cnt     <= '0;
        dvd_quo <= op1_abs;
        rem     <= '0;
        dsr     <= op2_abs;
        neg_q   <= op1_neg ^ op2_neg;
        neg_r   <= op1_neg;
      end else if ((state == ST_ON) && !abort) begin
        cnt     <= cnt + DIV_CNT_W'(1);
        dvd_quo <= quo_nxt;
        rem     <= rem_nxt;
      end

      // Result only moves on entry to END; an abort leaves it untouched.
      if (!abort) begin
        if (state == ST_DIV_ZERO) begin
          result_o <= '0;
        end else if (last_step) begin
          result_o <= {rem_fin, quo_fin};
        end
      end
    end
  end

  ready_single_pulse: assert property (
    @(posedge clk) disable iff (!rst) ready_o |=> !ready_o
  );

  cnt_in_range: assert property (
    @(posedge clk) disable iff (!rst) (state == ST_ON) |-> (cnt <= LAST_CNT)
  );

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: vector table for single operations plus
// hand-written flush, annul, reset and back-to-back sequences.
module tb_div_iter;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           flush = 1'b0;
  logic           annul_i = 1'b0;
  logic           start_i = 1'b0;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           ready_o;
  logic [2*W-1:0] result_o;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  div_iter #(
    .DATA_W (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .annul_i      (annul_i),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .ready_o      (ready_o),
    .result_o     (result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge with the DUT idle. lat is the number of
  // rising edges after the start edge until ready_o is seen (-1 if never).
  task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic [2*W-1:0] res);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = -1;
    res          = '0;
    for (int k = 0; k <= int'(W) + 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
      if (ready_o) begin
        lat = k;
        res = result_o;
        break;
      end
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int             lat;
    int             pulses;
    int             first;
    int             s1;
    int             s2;
    logic [2*W-1:0] res;
    logic [2*W-1:0] r1;
    logic [2*W-1:0] r2;
    logic [2*W-1:0] prev;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        32, "u_100_7"};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 32, "s_m7_2"};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        32, "s_min_m1"};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,        32'd0,        32'd0,        1,  "u_div0"};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        32, "u_max_1"};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        32, "s_7_m2"};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0,        32, "u_max_max"};
    vecs[7]  = '{1'b0, 32'd3,          32'd10,       32'd0,        32'd3,        32, "u_small"};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 32, "s_m100_m7"};
    vecs[9]  = '{1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 32'd1,        32, "u_msb_set"};
    vecs[10] = '{1'b1, 32'd0,          32'hFFFFFFFB, 32'd0,        32'd0,        32, "s_0_m5"};
    vecs[11] = '{1'b1, 32'hFFFFFFFB,   32'd0,        32'd0,        32'd0,        1,  "s_div0"};

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_result", 64'(result_o), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(ready_o), 64'(0));

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, res);
      check($sformatf("%s_lat", vecs[i].name), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("%s_quo", vecs[i].name), 64'(res[W-1:0]), 64'(vecs[i].q));
      check($sformatf("%s_rem", vecs[i].name), 64'(res[2*W-1:W]), 64'(vecs[i].r));
      check($sformatf("%s_pulse", vecs[i].name), 64'(ready_o), 64'(0));
    end

    // Flush at T+10 of a 100/7 divide.
    prev         = result_o;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    flush   = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    flush  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    check("flush_no_ready", 64'(pulses), 64'(0));
    check("flush_hold", 64'(result_o), 64'(prev));
    do_op(1'b0, 32'd100, 32'd7, lat, res);
    check("after_flush_lat", 64'(lat), 64'(W));
    check("after_flush_res", 64'(res), {32'd2, 32'd14});

    // Annul coinciding with start: nothing may start.
    prev         = result_o;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd5;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    pulses  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    check("annul_no_ready", 64'(pulses), 64'(0));
    check("annul_hold", 64'(result_o), 64'(prev));

    // Reset mid-ON with start held; new operands applied during reset.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (6) @(negedge clk);
    rst       = 1'b0;
    opdata1_i = 32'hFFFFFFFF;
    opdata2_i = 32'd1;
    @(negedge clk);
    check("midrst_ready", 64'(ready_o), 64'(0));
    check("midrst_result", 64'(result_o), 64'(0));
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    pulses = 0;
    first  = -1;
    res    = '0;
    for (int k = 0; k < int'(W) + 20; k++) begin
      @(negedge clk);
      if (ready_o) begin
        pulses++;
        if (first < 0) begin
          first = k;
          res   = result_o;
        end
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check("rst_op_pulses", 64'(pulses), 64'(1));
    check("rst_op_lat", 64'(first), 64'(W));
    check("rst_op_res", 64'(res), {32'd0, 32'hFFFFFFFF});

    // Back-to-back with start held high through END.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    pulses       = 0;
    s1           = -1;
    s2           = -1;
    r1           = '0;
    r2           = '0;
    for (int k = 0; k < 2 * int'(W) + 20; k++) begin
      @(negedge clk);
      if (ready_o) begin
        pulses++;
        if (s1 < 0) begin
          s1           = k;
          r1           = result_o;
          signed_div_i = 1'b1;
          opdata1_i    = 32'hFFFFFFF9;
          opdata2_i    = 32'd2;
        end else if (s2 < 0) begin
          s2      = k;
          r2      = result_o;
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    check("b2b_pulses", 64'(pulses), 64'(2));
    check("b2b_first_lat", 64'(s1), 64'(W));
    check("b2b_gap", 64'(s2 - s1), 64'(W + 2));
    check("b2b_res1", 64'(r1), {32'd2, 32'd14});
    check("b2b_res2", 64'(r2), {32'hFFFFFFFF, 32'hFFFFFFFD});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand width; quotient and remainder are each DATA_W bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  pipeline flush; aborts any operation in progress.
REQ-005 SHALL have port annul_i  input  1  abort request; same effect as flush.
REQ-006 SHALL have port start_i  input  1  initiator request; level-held until ready_o is seen.
REQ-007 SHALL have port signed_div_i  input  1  1 = signed divide, 0 = unsigned.
REQ-008 SHALL have port opdata1_i  input  DATA_W  dividend.
REQ-009 SHALL have port opdata2_i  input  DATA_W  divisor.
REQ-010 SHALL have port ready_o  output  1  result valid, one-cycle pulse.
REQ-011 SHALL have port result_o  output  2*DATA_W  {remainder, quotient}; the upper half is written to HI and the lower half to LO.

Function
REQ-012 SHALL implement the states IDLE, DIV_ZERO, ON and END.
REQ-013 In IDLE with start_i=1 and flush=annul_i=0, the block SHALL latch operands and signed_div_i, then enter DIV_ZERO if the divisor is 0, otherwise enter ON.
REQ-014 In ON, the block SHALL perform one restoring shift-subtract step per cycle on absolute values, for exactly DATA_W cycles, using a 6-bit iteration counter.
REQ-015 After the last ON step, the block SHALL enter END; ready_o SHALL be 1 only in END.
REQ-016 Latency SHALL be fixed: with start_i sampled at edge T, ready_o is high in cycle T+DATA_W+1 (T+33 for DATA_W=32).
REQ-017 DIV_ZERO SHALL last one cycle and then enter END with result_o = 0, so ready_o is high in cycle T+2.
REQ-018 END SHALL return to IDLE unconditionally on the next edge, so ready_o never lasts more than one cycle.
REQ-019 For signed operations, quotient sign SHALL be the XOR of the operand signs, and remainder sign SHALL follow the dividend; negation is two's complement at DATA_W bits.
REQ-020 Signed -2^31 / -1 SHALL give quotient 0x80000000 and remainder 0 (wrap, no exception).
REQ-021 result_o SHALL be registered, updated only on the transition into END, and held until the next transition into END.
REQ-022 start_i SHALL be ignored outside IDLE; operand changes during ON or DIV_ZERO SHALL have no effect.
REQ-023 flush=1 or annul_i=1 in any state SHALL force IDLE on the next edge, with ready_o=0 and result_o unchanged.
REQ-024 If flush or annul_i coincides with start_i in IDLE, the abort SHALL win and no operation starts.
REQ-025 If start_i is still 1 in the cycle after END, a new operation SHALL start from IDLE with the then-current operands.

Reset
REQ-026 When rst=0, the block SHALL asynchronously force state IDLE, counter 0, ready_o 0, result_o 0 and all operand/partial registers 0.
REQ-027 Reset asserted during ON SHALL discard the operation; after release, no ready_o occurs until a new start_i.

Structure
REQ-028 The state enumeration, DATA_W default and iteration-count constant SHALL reside in the shared package div_pkg.
REQ-029 The single shift-subtract step (partial remainder in, quotient bit and next partial remainder out) SHALL be a combinational sub-module div_step, instantiated once.

Verification
REQ-030 Unsigned: start with 100/7 -> ready_o at T+33 only, result_o = {0x00000002, 0x0000000E}.
REQ-031 Signed: -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; also 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
REQ-032 Divide by zero: 5/0 -> ready_o at T+2, result_o = 0.
REQ-033 Flush at cycle T+10 of a 100/7 divide -> no ready_o, result_o holds its previous value, and the next start gives a correct result with full latency.
REQ-034 Reset asserted mid-ON, start_i held across the reset window, then 0xFFFFFFFF/1 unsigned -> the aborted op never produces ready_o, and the new op gives quotient 0xFFFFFFFF, remainder 0.
REQ-035 Back-to-back: start_i held high through END -> the second op starts the cycle after END, with exactly one ready_o pulse per op.
